// File: rtl/button_calc_ctrl_if.sv
// Pushbutton calculator bus: raw buttons and switch operand in, accumulator,
// carry/borrow flag, display value, view mode and debug press pulses out.
//   master : drives btnU/btnD/btnL/btnR/btnC and sw, observes the results
//   slave  : the calculator controller itself
interface button_calc_ctrl_if;
    logic        btnU;
    logic        btnD;
    logic        btnL;
    logic        btnR;
    logic        btnC;
    logic [15:0] sw;
    logic [15:0] acc;
    logic        flag;
    logic [15:0] disp_value;
    logic [1:0]  mode;
    logic [4:0]  press;

    modport master (
        output btnU, btnD, btnL, btnR, btnC, sw,
        input  acc, flag, disp_value, mode, press
    );

    modport slave (
        input  btnU, btnD, btnL, btnR, btnC, sw,
        output acc, flag, disp_value, mode, press
    );
endinterface

// File: rtl/button_calc_ctrl.sv
// Five-button 16-bit accumulator calculator with debounced inputs and a
// LIVE / RESULT / PINNED display view.
//   clk, rst         : single clock, synchronous active-high reset
//   bus.btnU..btnC   : raw asynchronous pushbuttons (load, clear, sub, add, view)
//   bus.sw           : switch operand, registered once before use
//   bus.acc, flag    : accumulator and carry/borrow of the last add/subtract
//   bus.disp_value   : registered value for the hex display
//   bus.mode         : view state (0 LIVE, 1 RESULT, 2 PINNED)
//   bus.press        : accepted press pulses {U,D,L,R,C}
module button_calc_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 200000000
) (
    input  logic              clk,
    input  logic              rst,
    button_calc_ctrl_if.slave bus
);
    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        RESULT = 2'd1,
        PINNED = 2'd2
    } viewState_e;

    logic [NUM_BTN-1:0] btnRaw;
    logic [NUM_BTN-1:0] syncA;
    logic [NUM_BTN-1:0] syncB;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] pressReg;
    logic [DB_W-1:0]    dbCnt [NUM_BTN];

    logic [15:0]        swReg;
    logic [15:0]        accReg;
    logic               flagReg;
    logic [15:0]        dispReg;
    logic [HOLD_W-1:0]  holdTimer;
    viewState_e         view;

    logic [16:0]        sumFull;
    logic [16:0]        diffFull;
    logic               opPulse;
    logic               viewPulse;

    assign btnRaw = {bus.btnU, bus.btnD, bus.btnL, bus.btnR, bus.btnC};

    // Synchronize, debounce and turn accepted rising levels into single pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncA    <= '0;
            syncB    <= '0;
            level    <= '0;
            pressReg <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                dbCnt[i] <= '0;
            end
        end else begin
            syncA    <= btnRaw;
            syncB    <= syncA;
            pressReg <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (syncB[i] == level[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    // This sample is the DEBOUNCE_CYCLES-th consecutive difference.
                    dbCnt[i]    <= '0;
                    level[i]    <= ~level[i];
                    pressReg[i] <= ~level[i];
                end else begin
                    dbCnt[i] <= dbCnt[i] + DB_W'(1);
                end
            end
        end
    end

    // The 17th bit of each result is the carry (add) or borrow (subtract).
    assign sumFull   = {1'b0, accReg} + {1'b0, swReg};
    assign diffFull  = {1'b0, accReg} - {1'b0, swReg};
    assign opPulse   = |pressReg[4:1];
    assign viewPulse = pressReg[0] & ~opPulse;

    // Accumulator: only the highest-priority pulse acts (U > D > L > R).
    always_ff @(posedge clk) begin
        if (rst) begin
            swReg   <= '0;
            accReg  <= '0;
            flagReg <= 1'b0;
        end else begin
            swReg <= bus.sw;
            if (pressReg[4]) begin
                accReg  <= swReg;
                flagReg <= 1'b0;
            end else if (pressReg[3]) begin
                accReg  <= '0;
                flagReg <= 1'b0;
            end else if (pressReg[2]) begin
                accReg  <= diffFull[15:0];
                flagReg <= diffFull[16];
            end else if (pressReg[1]) begin
                accReg  <= sumFull[15:0];
                flagReg <= sumFull[16];
            end
        end
    end

    // View state, hold timer and display register.
    always_ff @(posedge clk) begin
        if (rst) begin
            view      <= LIVE;
            holdTimer <= '0;
            dispReg   <= '0;
        end else begin
            dispReg <= (view == LIVE) ? swReg : accReg;
            case (view)
                LIVE: begin
                    if (opPulse) begin
                        view      <= RESULT;
                        holdTimer <= HOLD_W'(HOLD_CYCLES - 1);
                    end else if (viewPulse) begin
                        view <= PINNED;
                    end
                end
                RESULT: begin
                    if (opPulse) begin
                        holdTimer <= HOLD_W'(HOLD_CYCLES - 1);
                    end else if (viewPulse) begin
                        view <= PINNED;
                    end else if (holdTimer == '0) begin
                        view <= LIVE;
                    end else begin
                        holdTimer <= holdTimer - HOLD_W'(1);
                    end
                end
                PINNED: begin
                    if (viewPulse) begin
                        view <= LIVE;
                    end
                end
                default: view <= LIVE;
            endcase
        end
    end

    assign bus.acc        = accReg;
    assign bus.flag       = flagReg;
    assign bus.disp_value = dispReg;
    assign bus.mode       = view;
    assign bus.press      = pressReg;
endmodule

// File: tb/tb_button_calc_ctrl.sv
// Self-checking bench for button_calc_ctrl (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8).
// A behavioural reference model tracks button stability runs, the calculator
// arithmetic and the view's remaining display time.
module tb_button_calc_ctrl;
    localparam int DB   = 4;
    localparam int HOLD = 8;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    button_calc_ctrl_if bus();

    button_calc_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    int         mAcc  = 0;
    int         mFlag = 0;
    int         mDisp = 0;
    int         mMode = 0;
    int         mSw   = 0;
    int         mLeft = 0;
    logic [4:0] mPress = '0;
    logic [4:0] d1 = '0;
    logic [4:0] d2 = '0;
    logic [4:0] lastSample = '0;
    logic [4:0] mLvl = '0;
    int         runLen [5];

    always @(posedge clk) begin : refModel
        logic [4:0] raw;
        logic [4:0] pulse;
        int         opSel;
        int         nDisp;
        int         s;
        raw = {bus.btnU, bus.btnD, bus.btnL, bus.btnR, bus.btnC};
        if (rst) begin
            mAcc = 0; mFlag = 0; mDisp = 0; mMode = 0; mSw = 0; mLeft = 0;
            mPress = '0; d1 = '0; d2 = '0; lastSample = '0; mLvl = '0;
            for (int i = 0; i < 5; i++) runLen[i] = 0;
        end else begin
            pulse = '0;
            for (int i = 0; i < 5; i++) begin
                // debouncer sees the button two samples late; accept after DB equal samples
                if (d2[i] == lastSample[i]) runLen[i] = (runLen[i] < DB) ? runLen[i] + 1 : DB;
                else runLen[i] = 1;
                lastSample[i] = d2[i];
                if (d2[i] != mLvl[i] && runLen[i] >= DB) begin
                    mLvl[i]  = d2[i];
                    pulse[i] = d2[i];
                end
            end
            d2 = d1;
            d1 = raw;

            opSel = -1;
            for (int i = 4; i >= 1; i--) if (mPress[i] && opSel < 0) opSel = i;
            nDisp = (mMode == 0) ? mSw : mAcc;
            case (opSel)
                4: begin mAcc = mSw; mFlag = 0; end
                3: begin mAcc = 0; mFlag = 0; end
                2: begin mFlag = (mSw > mAcc) ? 1 : 0; mAcc = (mAcc - mSw + 65536) % 65536; end
                1: begin s = mAcc + mSw; mFlag = (s > 65535) ? 1 : 0; mAcc = s % 65536; end
                default: ;
            endcase
            if (opSel >= 0) begin
                if (mMode != 2) begin mMode = 1; mLeft = HOLD; end
            end else if (mPress[0]) begin
                mMode = (mMode == 2) ? 0 : 2;
            end else if (mMode == 1) begin
                mLeft = mLeft - 1;
                if (mLeft == 0) mMode = 0;
            end
            mDisp  = nDisp;
            mSw    = int'(bus.sw);
            mPress = pulse;
        end
    end

    wire [39:0] dutVec = {bus.acc, bus.flag, bus.disp_value, bus.mode, bus.press};
    wire [39:0] expVec = {16'(mAcc), 1'(mFlag), 16'(mDisp), 2'(mMode), mPress};

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic setBtn(input logic [4:0] m);
        bus.btnU = m[4];
        bus.btnD = m[3];
        bus.btnL = m[2];
        bus.btnR = m[1];
        bus.btnC = m[0];
    endtask

    task automatic pressBtn(input logic [4:0] mask, input logic [15:0] swVal);
        bus.sw = swVal;
        tick(2);
        setBtn(mask);
        tick(8);
        setBtn('0);
        tick(6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setBtn(5'($urandom));
        bus.sw = 16'($urandom);
        tick(3);
        if (dutVec !== 40'd0) begin
            mismatched++;
            $display("FAIL reset_zero: dut=%h ref=%h", dutVec, 40'd0);
        end
        compared++;
        setBtn('0);
        tick(1);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (dutVec !== expVec) begin
                mismatched++;
                $display("FAIL reset_after cycle %0d: dut=%h ref=%h", c, dutVec, expVec);
            end
            compared++;
        end
    endtask

    task automatic test_load();
        int pulses = 0;
        int resultCycles = 0;
        bus.sw = 16'h1234;
        tick(2);
        for (int c = 0; c < 26; c++) begin
            bus.btnU = (c < 12);
            tick(1);
            if (bus.press[4] === 1'b1) pulses++;
            if (bus.mode === 2'd1) begin
                resultCycles++;
                if (bus.disp_value !== 16'h1234) begin
                    mismatched++;
                    $display("FAIL load_disp cycle %0d: dut=%h ref=1234", c, bus.disp_value);
                end
                compared++;
            end
            if (dutVec !== expVec) begin
                mismatched++;
                $display("FAIL load_model cycle %0d: dut=%h ref=%h", c, dutVec, expVec);
            end
            compared++;
        end
        if (pulses != 1 || resultCycles != HOLD) begin
            mismatched++;
            $display("FAIL load_counts: pulses=%0d result_cycles=%0d want 1/%0d", pulses, resultCycles, HOLD);
        end
        compared++;
        if (bus.acc !== 16'h1234 || bus.mode !== 2'd0) begin
            mismatched++;
            $display("FAIL load_final: acc=%h mode=%0d want 1234/0", bus.acc, bus.mode);
        end
        compared++;
    endtask

    task automatic test_add_wrap();
        pressBtn(5'b10000, 16'hFFFF);
        pressBtn(5'b00010, 16'h0002);
        if (bus.acc !== 16'h0001 || bus.flag !== 1'b1) begin
            mismatched++;
            $display("FAIL add_carry: acc=%h flag=%b want 0001/1", bus.acc, bus.flag);
        end
        compared++;
        pressBtn(5'b00010, 16'h0001);
        if (bus.acc !== 16'h0002 || bus.flag !== 1'b0) begin
            mismatched++;
            $display("FAIL add_nocarry: acc=%h flag=%b want 0002/0", bus.acc, bus.flag);
        end
        compared++;
        if (dutVec !== expVec) begin
            mismatched++;
            $display("FAIL add_model: dut=%h ref=%h", dutVec, expVec);
        end
        compared++;
    endtask

    task automatic test_sub_borrow();
        pressBtn(5'b10000, 16'h0003);
        pressBtn(5'b00100, 16'h0005);
        if (bus.acc !== 16'hFFFE || bus.flag !== 1'b1) begin
            mismatched++;
            $display("FAIL sub_borrow: acc=%h flag=%b want fffe/1", bus.acc, bus.flag);
        end
        compared++;
        pressBtn(5'b01000, 16'h0005);
        if (bus.acc !== 16'h0000 || bus.flag !== 1'b0) begin
            mismatched++;
            $display("FAIL clear: acc=%h flag=%b want 0000/0", bus.acc, bus.flag);
        end
        compared++;
        if (dutVec !== expVec) begin
            mismatched++;
            $display("FAIL sub_model: dut=%h ref=%h", dutVec, expVec);
        end
        compared++;
    endtask

    task automatic test_bounce();
        int accBefore;
        pressBtn(5'b10000, 16'h5A5A);
        accBefore = mAcc;
        bus.sw = 16'h0F0F;
        for (int c = 0; c < 40; c++) begin
            bus.btnU = (c < 30) ? (((c / 2) % 2) == 1) : 1'b0;
            tick(1);
            if (bus.press !== 5'd0 || bus.acc !== 16'(accBefore)) begin
                mismatched++;
                $display("FAIL bounce cycle %0d: press=%b acc=%h want 00000/%h", c, bus.press, bus.acc, 16'(accBefore));
            end
            compared++;
            if (dutVec !== expVec) begin
                mismatched++;
                $display("FAIL bounce_model cycle %0d: dut=%h ref=%h", c, dutVec, expVec);
            end
            compared++;
        end
    endtask

    task automatic test_priority_view();
        pressBtn(5'b10000, 16'h0010);
        pressBtn(5'b10010, 16'h0001);
        if (bus.acc !== 16'h0001 || bus.flag !== 1'b0) begin
            mismatched++;
            $display("FAIL priority: acc=%h flag=%b want 0001/0", bus.acc, bus.flag);
        end
        compared++;
        pressBtn(5'b00001, 16'h0777);
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (bus.mode !== 2'd2 || bus.disp_value !== 16'h0001) begin
                mismatched++;
                $display("FAIL pinned cycle %0d: mode=%0d disp=%h want 2/0001", c, bus.mode, bus.disp_value);
            end
            compared++;
        end
        pressBtn(5'b00001, 16'h0777);
        if (bus.mode !== 2'd0 || bus.disp_value !== 16'h0777) begin
            mismatched++;
            $display("FAIL unpin: mode=%0d disp=%h want 0/0777", bus.mode, bus.disp_value);
        end
        compared++;
        if (dutVec !== expVec) begin
            mismatched++;
            $display("FAIL view_model: dut=%h ref=%h", dutVec, expVec);
        end
        compared++;
    endtask

    task automatic test_reset_mid_hold();
        logic found;
        int   pulses;
        bus.sw = 16'h00AB;
        tick(2);
        setBtn(5'b00010);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick(1);
            if (bus.mode === 2'd1) found = 1'b1;
        end
        if (!found) begin
            mismatched++;
            $display("FAIL hold_enter: mode=%0d want 1 within 20 cycles", bus.mode);
        end
        compared++;
        tick(2);
        rst = 1'b1;
        setBtn('0);
        tick(1);
        if (bus.acc !== 16'd0 || bus.flag !== 1'b0 || bus.mode !== 2'd0 || bus.disp_value !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_hold: acc=%h flag=%b mode=%0d disp=%h want all 0", bus.acc, bus.flag, bus.mode, bus.disp_value);
        end
        compared++;
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            if (bus.press !== 5'd0 || dutVec !== expVec) begin
                mismatched++;
                $display("FAIL reset_stale cycle %0d: dut=%h ref=%h", c, dutVec, expVec);
            end
            compared++;
        end
        // button held through reset release yields exactly one pulse
        rst = 1'b1;
        setBtn(5'b01000);
        tick(2);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            tick(1);
            if (bus.press[3] === 1'b1) pulses++;
            if (dutVec !== expVec) begin
                mismatched++;
                $display("FAIL held_model cycle %0d: dut=%h ref=%h", c, dutVec, expVec);
            end
            compared++;
        end
        if (pulses != 1) begin
            mismatched++;
            $display("FAIL held_pulse: pulses=%0d want 1", pulses);
        end
        compared++;
        setBtn('0);
        tick(6);
    endtask

    task automatic test_random();
        logic [4:0] lvl;
        lvl = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(11) == 0) lvl[b] = ~lvl[b];
            end
            setBtn(lvl);
            if ($urandom_range(15) == 0) bus.sw = 16'($urandom);
            rst = ($urandom_range(399) == 0);
            tick(1);
            if (dutVec !== expVec) begin
                mismatched++;
                $display("FAIL random cycle %0d: dut=%h ref=%h", c, dutVec, expVec);
            end
            compared++;
        end
        rst = 1'b0;
        setBtn('0);
        tick(4);
    endtask

    initial begin
        rst = 1'b1;
        setBtn('0);
        bus.sw = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_add_wrap();
        test_sub_borrow();
        test_bounce();
        test_priority_view();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/button_calc_ctrl.md
BUTTON_CALC_CTRL -- requirements
Module: button_calc_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 200000000, meaning how many cycles a result stays displayed before the view returns to live.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports btnU, btnD, btnL, btnR and btnC, each an input of 1 bit: raw asynchronous pushbuttons, active high.
REQ-006 The block SHALL have port sw, input, 16 bits: switch operand, asynchronous and slowly changing.
REQ-007 The block SHALL have port acc, output, 16 bits: the accumulator register.
REQ-008 The block SHALL have port flag, output, 1 bit: carry/borrow from the last add or subtract.
REQ-009 The block SHALL have port disp_value, output, 16 bits: registered value for the hex display.
REQ-010 The block SHALL have port mode, output, 2 bits: view state (0 = LIVE, 1 = RESULT, 2 = PINNED).
REQ-011 The block SHALL have port press, output, 5 bits: debug copy of the accepted press pulses {U,D,L,R,C}.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and then a debouncer with a DEBOUNCE_CYCLES counter.
REQ-013 When the synchronized level differs from the accepted level, the debounce counter SHALL increment every cycle.
REQ-014 When the synchronized level equals the accepted level, the debounce counter SHALL reset to 0.
REQ-015 When the debounce counter reaches DEBOUNCE_CYCLES, the accepted level SHALL flip and the counter SHALL clear.
REQ-016 An accepted 0->1 transition SHALL produce exactly one 1-cycle press pulse; an accepted 1->0 transition SHALL produce no pulse.
REQ-017 Holding a button SHALL never repeat its pulse.
REQ-018 sw SHALL be registered once, and that registered copy SHALL be used for all operations.
REQ-019 When several pulses occur in one cycle, only the highest-priority one SHALL act, in the order U > D > L > R > C; the others SHALL be discarded.
REQ-020 A U pulse SHALL perform a load: acc <= sw, flag <= 0.
REQ-021 A D pulse SHALL perform a clear: acc <= 0, flag <= 0.
REQ-022 An L pulse SHALL perform a subtract: acc <= (acc - sw) mod 2^16, flag <= 1 exactly when sw > acc (unsigned borrow).
REQ-023 An R pulse SHALL perform an add: acc <= (acc + sw) mod 2^16, flag <= carry-out of the 17-bit sum.
REQ-024 A C pulse SHALL change only the view state, never acc or flag.
REQ-025 The result of an operation whose pulse is high in cycle N SHALL be visible on acc and flag in cycle N+1.
REQ-026 From LIVE, an operation pulse SHALL move the view to RESULT and load the hold timer with HOLD_CYCLES-1.
REQ-027 From LIVE, a C pulse SHALL move the view to PINNED.
REQ-028 In RESULT, the hold timer SHALL decrement each cycle, and the view SHALL go to LIVE on the cycle after the timer reaches 0.
REQ-029 In RESULT, an operation pulse SHALL reload the hold timer and keep the view in RESULT.
REQ-030 In RESULT, a C pulse SHALL move the view to PINNED.
REQ-031 In PINNED, an operation pulse SHALL keep the view in PINNED, with acc still updated.
REQ-032 In PINNED, a C pulse SHALL move the view to LIVE.
REQ-033 disp_value SHALL be registered as the registered sw when the view is LIVE, and as acc when the view is RESULT or PINNED.
REQ-034 disp_value SHALL reflect an acc update in cycle N+2 relative to the pulse.
REQ-035 Unused mode encoding 3 SHALL return the view to LIVE on the next cycle.

Reset
REQ-036 While rst is high at a clock edge, acc, flag, disp_value, press, the debounce counters, the hold timer and the synchronizers SHALL all be 0, the accepted levels SHALL be 0, and mode SHALL be LIVE.
REQ-037 Reset SHALL take priority over every pulse in the same cycle, and SHALL abort a RESULT hold in progress.
REQ-038 A button held through the deassertion of rst SHALL produce one pulse after debouncing completes.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-039 Load: sw=0x1234, btnU high for 12 cycles -> exactly one press[4] pulse, acc=0x1234 one cycle later, mode=1 for 8 cycles and then 0, disp_value=0x1234 throughout the hold.
REQ-040 Add wrap: acc=0xFFFF, sw=0x0002, R press -> acc=0x0001 and flag=1; then sw=0x0001, R press -> acc=0x0002 and flag=0.
REQ-041 Subtract borrow: acc=0x0003, sw=0x0005, L press -> acc=0xFFFE and flag=1; then D press -> acc=0x0000 and flag=0.
REQ-042 Bounce: btnU toggling every 2 cycles for 30 cycles and then low -> no press pulse, acc unchanged.
REQ-043 Priority and view: btnU and btnR rising in the same cycle with acc=0x0010 and sw=0x0001 -> acc=0x0001 (load only); a following C press gives mode=2 with disp_value=acc held past 8 cycles; a second C press gives mode=0.
REQ-044 Reset mid-hold: rst asserted 3 cycles into RESULT -> acc=0, flag=0, mode=0 and disp_value=0 on the next edge, and no stale pulse after release.
